// File: rtl/vc_output_arbiter.sv
// ---------------------------------------------------------------------------
// vc_output_arbiter
//
// Wormhole output arbiter placed between the per-port VC buffers and the VC
// output multiplexer. In IDLE it picks one eligible VC (head or single flit at
// its buffer head) with round-robin priority and registers that choice as the
// mux plane selector. In LOCKED it streams that VC's flits to the switch with a
// valid/ready handshake until a tail (or single) flit is consumed, so flits of
// different packets never interleave on the output.
//
// Ports:
//   clk              clock, all state changes on the rising edge
//   rst              synchronous reset, active low (0 = reset)
//   vcValid[VC]      bit i: VC buffer i holds a flit at its head
//   vcFlitType       head-flit type of VC i at [i*TYPE_WIDTH +: TYPE_WIDTH]
//                    (01 head, 00 body, 10 tail, 11 single)
//   vcPop[VC]        one-hot: consume the head flit of VC buffer i this cycle
//   VCPlaneSelector  binary index of the granted plane, zero-extended
//   switchValid      flit presented through the mux is valid
//   switchReady      switch accepts the presented flit this cycle
//   locked           a packet is in flight
//   protocolError    sticky flit-type violation flag, cleared by reset only
// ---------------------------------------------------------------------------
module vc_output_arbiter #(
    parameter int VC         = 4,
    parameter int TYPE_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VC-1:0]            vcValid,
    input  logic [VC*TYPE_WIDTH-1:0] vcFlitType,
    output logic [VC-1:0]            vcPop,
    output logic [VC:0]              VCPlaneSelector,
    output logic                     switchValid,
    input  logic                     switchReady,
    output logic                     locked,
    output logic                     protocolError
);

    localparam int IW = (VC > 1) ? $clog2(VC) : 1;

    localparam logic [TYPE_WIDTH-1:0] T_BODY   = TYPE_WIDTH'(2'b00);
    localparam logic [TYPE_WIDTH-1:0] T_HEAD   = TYPE_WIDTH'(2'b01);
    localparam logic [TYPE_WIDTH-1:0] T_TAIL   = TYPE_WIDTH'(2'b10);
    localparam logic [TYPE_WIDTH-1:0] T_SINGLE = TYPE_WIDTH'(2'b11);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   sel_q,   sel_d;
    logic [IW-1:0]   rr_q,    rr_d;
    logic            first_q, first_d;   // next pop is the packet's first flit
    logic            err_q,   err_d;

    // Per-VC decode of the flit type at each buffer head.
    logic [TYPE_WIDTH-1:0] flit_type [VC];
    logic [VC-1:0]         is_start;     // head or single
    logic [VC-1:0]         eligible;
    logic [VC-1:0]         misplaced;    // valid body/tail seen while idle

    generate
        for (genvar gi = 0; gi < VC; gi++) begin : g_decode
            assign flit_type[gi] = vcFlitType[gi*TYPE_WIDTH +: TYPE_WIDTH];
            assign is_start[gi]  = (flit_type[gi] == T_HEAD) ||
                                   (flit_type[gi] == T_SINGLE);
            assign eligible[gi]  = vcValid[gi] & is_start[gi];
            assign misplaced[gi] = vcValid[gi] & ~is_start[gi];
        end
    endgenerate

    // Round-robin pick: first eligible index starting at rr_q, wrapping.
    logic          grant_found;
    logic [IW-1:0] grant_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < VC; k++) begin : scan
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= VC) begin
                idx = idx - VC;
            end
            if (!grant_found && eligible[IW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    // Handshake on the granted plane. Gating with rst guarantees no pop is
    // issued in a reset cycle even if the state register is still LOCKED.
    logic                  in_locked;
    logic                  grant_valid;
    logic                  pop_fire;
    logic [TYPE_WIDTH-1:0] g_type;
    logic                  g_last;

    assign in_locked   = (state_q == S_LOCKED);
    assign grant_valid = in_locked & rst & vcValid[sel_q];
    assign pop_fire    = grant_valid & switchReady;
    assign g_type      = flit_type[sel_q];
    assign g_last      = (g_type == T_TAIL) || (g_type == T_SINGLE);

    assign switchValid     = grant_valid;
    assign vcPop           = pop_fire ? (VC'(1) << sel_q) : '0;
    assign VCPlaneSelector = (VC+1)'(sel_q);
    assign locked          = in_locked;
    assign protocolError   = err_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        first_d = first_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (|misplaced) begin
                    err_d = 1'b1;
                end
                if (grant_found) begin
                    sel_d   = grant_idx;
                    first_d = 1'b1;
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (pop_fire) begin
                    first_d = 1'b0;
                    // A packet start mid-packet is flagged but still forwarded.
                    if (!first_q && is_start[sel_q]) begin
                        err_d = 1'b1;
                    end
                    if (g_last) begin
                        state_d = S_IDLE;
                        rr_d    = (sel_q == IW'(VC-1)) ? '0 : sel_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    // Body type constant is part of the encoding; referenced to keep the
    // full type table visible next to the decode.
    logic unused_body;
    assign unused_body = (T_BODY == T_BODY);

endmodule

// File: tb/tb_vc_output_arbiter.sv
module tb_vc_output_arbiter;

    localparam logic [1:0] HEAD = 2'b01, BODY = 2'b00, TAIL = 2'b10, SINGLE = 2'b11;

    logic       clk, rst;
    logic [3:0] vcValid;
    logic [7:0] vcFlitType;
    logic [3:0] vcPop;
    logic [4:0] VCPlaneSelector;
    logic       switchValid, switchReady, locked, protocolError;

    vc_output_arbiter #(.VC(4), .TYPE_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .vcValid(vcValid), .vcFlitType(vcFlitType),
        .vcPop(vcPop), .VCPlaneSelector(VCPlaneSelector),
        .switchValid(switchValid), .switchReady(switchReady),
        .locked(locked), .protocolError(protocolError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // VC buffer contents (flit types) and per-VC bubble mask.
    logic [1:0] fq [4][$];
    logic [3:0] bub;

    // Behavioural model: packet-level view of the output port.
    bit m_busy = 0, m_first = 0, m_err = 0;
    int m_g = 0, m_rr = 0;

    logic [3:0] e_pop;
    logic       e_valid, e_locked, e_err;
    logic [4:0] e_sel;

    function automatic bit is_start(logic [1:0] t);
        return (t == HEAD) || (t == SINGLE);
    endfunction

    // Present buffer heads to the DUT and predict the outputs for this cycle.
    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            vcValid[i] = (fq[i].size() > 0) && !bub[i];
            vcFlitType[i*2 +: 2] = (fq[i].size() > 0) ? fq[i][0] : BODY;
        end
        e_sel    = 5'(m_g);
        e_locked = m_busy;
        e_err    = m_err;
        e_valid  = rst && m_busy && vcValid[m_g];
        e_pop    = (e_valid && switchReady) ? 4'(1 << m_g) : 4'b0;
    endtask

    // Advance one clock and update the model / buffers.
    task automatic tick();
        logic [1:0] ty;
        bit found;
        int idx;
        @(posedge clk);
        if (!rst) begin
            m_busy = 0; m_first = 0; m_err = 0; m_g = 0; m_rr = 0;
        end else if (m_busy) begin
            if (e_pop != 4'b0) begin
                ty = fq[m_g].pop_front();
                if (!m_first && is_start(ty)) m_err = 1;
                m_first = 0;
                if (ty == TAIL || ty == SINGLE) begin
                    m_busy = 0;
                    m_rr = (m_g + 1) % 4;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++)
                if (vcValid[i] && !is_start(vcFlitType[i*2 +: 2])) m_err = 1;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                idx = (m_rr + k) % 4;
                if (!found && vcValid[idx] && is_start(vcFlitType[idx*2 +: 2])) begin
                    found = 1; m_busy = 1; m_first = 1; m_g = idx;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(int n);
        rst = 1'b0; bub = '0; switchReady = 1'b0;
        for (int i = 0; i < 4; i++) fq[i].delete();
        for (int c = 0; c < n; c++) begin apply(); tick(); end
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; bub = '0; switchReady = 1'b0;
        for (int c = 0; c < 2; c++) begin
            apply();
            #1;
            if (c == 1) begin
                checks++;
                if ({vcPop, switchValid, VCPlaneSelector, locked, protocolError} !== 12'b0) begin
                    errors++;
                    $display("FAIL reset_state: got pop=%b valid=%b sel=%0d locked=%b err=%b, expected all zero",
                             vcPop, switchValid, VCPlaneSelector, locked, protocolError);
                end
            end
            tick();
        end
        // Reset while a packet is in flight: no pop in the reset cycle.
        rst = 1'b1; switchReady = 1'b1;
        fq[0].push_back(HEAD); fq[0].push_back(TAIL);
        apply(); tick();
        rst = 1'b0;
        apply(); #1;
        checks++;
        if (vcPop !== 4'b0) begin
            errors++; $display("FAIL reset_no_pop: got vcPop=%b expected 0000", vcPop);
        end
        tick();
        apply(); #1;
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL reset_abandon: got locked=%b expected 0", locked);
        end
        tick();
    endtask

    task automatic test_single_packet();
        int pops = 0, first_c = -1, last_c = -1;
        do_reset(2);
        switchReady = 1'b1;
        fq[2].push_back(HEAD); fq[2].push_back(BODY); fq[2].push_back(TAIL);
        for (int c = 0; c < 6; c++) begin
            apply(); #1;
            checks++;
            if ({vcPop, switchValid, VCPlaneSelector, locked, protocolError} !== {e_pop, e_valid, e_sel, e_locked, e_err}) begin
                errors++;
                $display("FAIL single_pkt cycle %0d: got %b expected %b", c,
                         {vcPop, switchValid, VCPlaneSelector, locked, protocolError},
                         {e_pop, e_valid, e_sel, e_locked, e_err});
            end
            if (c == 1) begin
                checks++;
                if (VCPlaneSelector !== 5'd2) begin
                    errors++; $display("FAIL single_pkt_grant: got sel=%0d expected 2", VCPlaneSelector);
                end
            end
            if (vcPop == 4'b0100) begin
                pops++; if (first_c < 0) first_c = c; last_c = c;
            end
            tick();
        end
        checks++;
        if (pops != 3 || first_c != 1 || last_c != 3) begin
            errors++; $display("FAIL single_pkt_pops: got %0d pops in cycles %0d..%0d expected 3 in 1..3", pops, first_c, last_c);
        end
        // rrPointer must now be 3: with VC0 and VC3 both eligible, VC3 wins.
        fq[0].push_back(SINGLE); fq[3].push_back(SINGLE);
        apply(); tick();
        apply(); #1;
        checks++;
        if (VCPlaneSelector !== 5'd3) begin
            errors++; $display("FAIL rr_after_tail: got sel=%0d expected 3", VCPlaneSelector);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [$];
        int cyc [$];
        logic [3:0] want [5];
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000; want[4] = 4'b0001;
        do_reset(1);
        switchReady = 1'b1;
        for (int i = 0; i < 4; i++) begin fq[i].push_back(SINGLE); fq[i].push_back(SINGLE); end
        for (int c = 0; c < 11; c++) begin
            apply(); #1;
            checks++;
            if ({vcPop, switchValid, VCPlaneSelector, locked, protocolError} !== {e_pop, e_valid, e_sel, e_locked, e_err}) begin
                errors++;
                $display("FAIL round_robin cycle %0d: got %b expected %b", c,
                         {vcPop, switchValid, VCPlaneSelector, locked, protocolError},
                         {e_pop, e_valid, e_sel, e_locked, e_err});
            end
            if (vcPop != 4'b0) begin seq.push_back(vcPop); cyc.push_back(c); end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= seq.size() || seq[k] !== want[k] || cyc[k] != 2*k + 1) begin
                errors++;
                $display("FAIL round_robin_seq pop %0d: got %b at cycle %0d expected %b at cycle %0d", k,
                         (k < seq.size()) ? seq[k] : 4'bxxxx, (k < cyc.size()) ? cyc[k] : -1, want[k], 2*k + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        do_reset(1);
        fq[1].push_back(HEAD); fq[1].push_back(BODY); fq[1].push_back(BODY); fq[1].push_back(TAIL);
        for (int c = 0; c < 11; c++) begin
            switchReady = !(c >= 2 && c <= 4);
            bub = (c == 6) ? 4'b0010 : 4'b0000;
            apply(); #1;
            checks++;
            if ({vcPop, switchValid, VCPlaneSelector, locked, protocolError} !== {e_pop, e_valid, e_sel, e_locked, e_err}) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got %b expected %b", c,
                         {vcPop, switchValid, VCPlaneSelector, locked, protocolError},
                         {e_pop, e_valid, e_sel, e_locked, e_err});
            end
            if (c >= 1 && c <= 8) begin
                checks++;
                if (locked !== 1'b1 || VCPlaneSelector !== 5'd1) begin
                    errors++; $display("FAIL backpressure_hold cycle %0d: got locked=%b sel=%0d expected 1/1", c, locked, VCPlaneSelector);
                end
            end
            if ((c >= 2 && c <= 4) || c == 6) begin
                checks++;
                if (vcPop !== 4'b0) begin
                    errors++; $display("FAIL backpressure_stall cycle %0d: got vcPop=%b expected 0000", c, vcPop);
                end
            end
            if (vcPop == 4'b0010) pops++;
            tick();
        end
        checks++;
        if (pops != 4 || locked !== 1'b0) begin
            errors++; $display("FAIL backpressure_total: got %0d pops locked=%b expected 4 pops locked=0", pops, locked);
        end
    endtask

    task automatic test_wormhole();
        int vc0_pops = 0;
        bit early = 0;
        do_reset(1);
        fq[0].push_back(HEAD); fq[0].push_back(BODY); fq[0].push_back(BODY); fq[0].push_back(TAIL);
        for (int c = 0; c < 10; c++) begin
            switchReady = (c != 2);
            if (c == 2) begin fq[3].push_back(HEAD); fq[3].push_back(TAIL); end
            apply(); #1;
            checks++;
            if ({vcPop, switchValid, VCPlaneSelector, locked, protocolError} !== {e_pop, e_valid, e_sel, e_locked, e_err}) begin
                errors++;
                $display("FAIL wormhole cycle %0d: got %b expected %b", c,
                         {vcPop, switchValid, VCPlaneSelector, locked, protocolError},
                         {e_pop, e_valid, e_sel, e_locked, e_err});
            end
            if (vcPop[3] && vc0_pops < 4) early = 1;
            if (vcPop[0]) vc0_pops++;
            if (c == 7) begin
                checks++;
                if (VCPlaneSelector !== 5'd3 || vcPop !== 4'b1000) begin
                    errors++; $display("FAIL wormhole_next: got sel=%0d pop=%b expected sel=3 pop=1000", VCPlaneSelector, vcPop);
                end
            end
            tick();
        end
        checks++;
        if (early || vc0_pops != 4) begin
            errors++; $display("FAIL wormhole_interleave: got vc0_pops=%0d early_vc3=%0d expected 4 and 0", vc0_pops, early);
        end
    endtask

    task automatic test_protocol_error();
        do_reset(1);
        switchReady = 1'b1;
        fq[1].push_back(BODY);
        for (int c = 0; c < 8; c++) begin
            if (c == 2) fq[0].push_back(SINGLE);
            apply(); #1;
            checks++;
            if ({vcPop, switchValid, VCPlaneSelector, locked, protocolError} !== {e_pop, e_valid, e_sel, e_locked, e_err}) begin
                errors++;
                $display("FAIL proto_err cycle %0d: got %b expected %b", c,
                         {vcPop, switchValid, VCPlaneSelector, locked, protocolError},
                         {e_pop, e_valid, e_sel, e_locked, e_err});
            end
            if (c == 1) begin
                checks++;
                if (protocolError !== 1'b1 || locked !== 1'b0) begin
                    errors++; $display("FAIL proto_err_set: got err=%b locked=%b expected 1/0", protocolError, locked);
                end
            end
            if (c >= 1) begin
                checks++;
                if (protocolError !== 1'b1 || vcPop[1] !== 1'b0) begin
                    errors++; $display("FAIL proto_err_sticky cycle %0d: got err=%b pop1=%b expected 1/0", c, protocolError, vcPop[1]);
                end
            end
            tick();
        end
        do_reset(1);
        apply(); #1;
        checks++;
        if (protocolError !== 1'b0) begin
            errors++; $display("FAIL proto_err_clear: got err=%b expected 0", protocolError);
        end
        // A second head inside a packet is flagged but forwarded.
        switchReady = 1'b1;
        fq[2].push_back(HEAD); fq[2].push_back(HEAD); fq[2].push_back(TAIL);
        for (int c = 0; c < 6; c++) begin
            apply(); #1;
            checks++;
            if ({vcPop, switchValid, VCPlaneSelector, locked, protocolError} !== {e_pop, e_valid, e_sel, e_locked, e_err}) begin
                errors++;
                $display("FAIL mid_head cycle %0d: got %b expected %b", c,
                         {vcPop, switchValid, VCPlaneSelector, locked, protocolError},
                         {e_pop, e_valid, e_sel, e_locked, e_err});
            end
            tick();
        end
        checks++;
        if (protocolError !== 1'b1 || fq[2].size() != 0) begin
            errors++; $display("FAIL mid_head_flag: got err=%b remaining=%0d expected 1/0", protocolError, fq[2].size());
        end
    endtask

    task automatic test_random();
        int len, v;
        do_reset(1);
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                for (int i = 0; i < 4; i++) fq[i].delete();
            end else begin
                rst = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) begin
                v = $urandom_range(0, 3);
                if (fq[v].size() < 6) begin
                    len = $urandom_range(1, 4);
                    if (len == 1) fq[v].push_back(SINGLE);
                    else begin
                        fq[v].push_back(HEAD);
                        for (int k = 0; k < len - 2; k++) fq[v].push_back(BODY);
                        fq[v].push_back(TAIL);
                    end
                end
            end
            for (int i = 0; i < 4; i++) bub[i] = ($urandom_range(0, 7) == 0);
            switchReady = ($urandom_range(0, 3) != 0);
            apply(); #1;
            checks++;
            if ({vcPop, switchValid, VCPlaneSelector, locked, protocolError} !== {e_pop, e_valid, e_sel, e_locked, e_err}) begin
                errors++;
                $display("FAIL random cycle %0d: got %b expected %b", c,
                         {vcPop, switchValid, VCPlaneSelector, locked, protocolError},
                         {e_pop, e_valid, e_sel, e_locked, e_err});
            end
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; vcValid = '0; vcFlitType = '0; switchReady = 1'b0; bub = '0;
        @(negedge clk);
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_wormhole();
        test_protocol_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
